// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Response checker for gate-level self-test of datapath cells. It takes a
//   stream of observed/expected/mask beats and compares each beat under its
//   mask. It counts mismatching beats, keeps the first failing vector, and
//   reports pass/fail after NUM_VECTORS beats have been checked.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           one-cycle pulse, begins a run from IDLE or DONE
//   in_valid        observed/expected/mask beat valid
//   in_ready        checker accepts a beat this cycle (RUN only)
//   observed        DUT output word
//   expected        golden word
//   mask            1 = bit compared, 0 = don't care
//   busy            run in progress (RUN or DRAIN)
//   done            results valid, held until start or rst
//   pass            done && err_count == 0
//   err_count       mismatching beats, saturating
//   first_err_idx   beat index of the first mismatch
//   first_err_obs   observed word of the first mismatch
//   first_err_exp   expected word of the first mismatch
module gate_vector_checker #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_VECTORS = 16,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] observed,
   input  logic [WIDTH-1:0] expected,
   input  logic [WIDTH-1:0] mask,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [IDX_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_obs,
   output logic [WIDTH-1:0] first_err_exp
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VECTORS - 1);

   state_e           state_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             done_q;
   logic [IDX_W-1:0] vec_idx_q;

   // Stage 1: registered compare result of the accepted beat
   logic             s1_valid_q;
   logic             s1_mismatch_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [WIDTH-1:0] s1_obs_q;
   logic [WIDTH-1:0] s1_exp_q;

   // Stage 2: accumulated results
   logic [CNT_W-1:0] err_count_q;
   logic             captured_q;
   logic [IDX_W-1:0] first_idx_q;
   logic [WIDTH-1:0] first_obs_q;
   logic [WIDTH-1:0] first_exp_q;

   logic accept;
   logic beat_mismatch;

   assign accept        = in_valid && in_ready_q;
   assign beat_mismatch = |((observed ^ expected) & mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         in_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         vec_idx_q     <= '0;
         s1_valid_q    <= 1'b0;
         s1_mismatch_q <= 1'b0;
         s1_idx_q      <= '0;
         s1_obs_q      <= '0;
         s1_exp_q      <= '0;
         err_count_q   <= '0;
         captured_q    <= 1'b0;
         first_idx_q   <= '0;
         first_obs_q   <= '0;
         first_exp_q   <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_mismatch_q <= beat_mismatch;
            s1_idx_q      <= vec_idx_q;
            s1_obs_q      <= observed;
            s1_exp_q      <= expected;
            vec_idx_q     <= vec_idx_q + 1'b1;
         end

         if (s1_valid_q && s1_mismatch_q) begin
            if (err_count_q != '1) begin
               err_count_q <= err_count_q + 1'b1;
            end
            if (!captured_q) begin
               captured_q  <= 1'b1;
               first_idx_q <= s1_idx_q;
               first_obs_q <= s1_obs_q;
               first_exp_q <= s1_exp_q;
            end
         end

         case (state_q)
            StIdle, StDone: begin
               // Stage 2 is idle outside RUN/DRAIN, so these clears never race a retire.
               if (start) begin
                  state_q     <= StRun;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  vec_idx_q   <= '0;
                  err_count_q <= '0;
                  captured_q  <= 1'b0;
                  first_idx_q <= '0;
                  first_obs_q <= '0;
                  first_exp_q <= '0;
               end
            end
            StRun: begin
               if (accept && (vec_idx_q == LastIdx)) begin
                  state_q    <= StDrain;
                  in_ready_q <= 1'b0;
               end
            end
            StDrain: begin
               // One cycle lets the last beat retire through stage 2.
               state_q <= StDone;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = done_q && (err_count_q == '0);
   assign err_count     = err_count_q;
   assign first_err_idx = first_idx_q;
   assign first_err_obs = first_obs_q;
   assign first_err_exp = first_exp_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
//   Randomised self-checking bench for gate_vector_checker. Each run's
//   expected results are computed from the whole vector set up front
//   (saturating mismatch count, first failing beat).
module tb_gate_vector_checker;

   localparam int unsigned W      = 32;
   localparam int unsigned NV     = 4;
   localparam int unsigned IW     = 4;
   localparam int unsigned CW     = 2;
   localparam int          MaxCnt = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  observed;
   logic [W-1:0]  expected;
   logic [W-1:0]  mask;
   logic          busy;
   logic          done;
   logic          pass;
   logic [CW-1:0] err_count;
   logic [IW-1:0] first_err_idx;
   logic [W-1:0]  first_err_obs;
   logic [W-1:0]  first_err_exp;

   int n_total = 0;
   int n_bad   = 0;

   logic [W-1:0] obs_a [NV];
   logic [W-1:0] exp_a [NV];
   logic [W-1:0] msk_a [NV];
   bit           gap_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

   gate_vector_checker #(
      .WIDTH       (W),
      .NUM_VECTORS (NV),
      .IDX_W       (IW),
      .CNT_W       (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .observed      (observed),
      .expected      (expected),
      .mask          (mask),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_obs (first_err_obs),
      .first_err_exp (first_err_exp)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ":in_ready"}, 64'(in_ready), 0);
      check_val({tag, ":busy"}, 64'(busy), 0);
      check_val({tag, ":done"}, 64'(done), 0);
      check_val({tag, ":pass"}, 64'(pass), 0);
      check_val({tag, ":err"}, 64'(err_count), 0);
      check_val({tag, ":fidx"}, 64'(first_err_idx), 0);
      check_val({tag, ":fobs"}, 64'(first_err_obs), 0);
      check_val({tag, ":fexp"}, 64'(first_err_exp), 0);
   endtask

   task automatic fill(input logic [W-1:0] o, input logic [W-1:0] e, input logic [W-1:0] m);
      for (int k = 0; k < NV; k++) begin
         obs_a[k] = o;
         exp_a[k] = e;
         msk_a[k] = m;
      end
   endtask

   // Entered and left at a negative edge. gap_mode: 0 back-to-back, 1 fixed, 2 random.
   task automatic run_check(input string tag, input int gap_mode, input bit mid_start);
      int           ec;
      bit           seen;
      logic [IW-1:0] fi;
      logic [W-1:0] fo;
      logic [W-1:0] fe;
      int           i;
      int           cyc;
      bit           acc;

      ec   = 0;
      seen = 0;
      fi   = '0;
      fo   = '0;
      fe   = '0;
      for (int k = 0; k < NV; k++) begin
         if (((obs_a[k] ^ exp_a[k]) & msk_a[k]) != '0) begin
            if (ec < MaxCnt) ec++;
            if (!seen) begin
               seen = 1;
               fi   = IW'(k);
               fo   = obs_a[k];
               fe   = exp_a[k];
            end
         end
      end

      // Start with a stray mismatching beat alongside; it must not be taken.
      start    = 1'b1;
      in_valid = 1'b1;
      observed = 32'hDEAD_BEEF;
      expected = '0;
      mask     = '1;
      check_val({tag, ":rdy_at_start"}, 64'(in_ready), 0);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      check_val({tag, ":run_busy"}, 64'(busy), 1);
      check_val({tag, ":run_done"}, 64'(done), 0);
      check_val({tag, ":run_err"}, 64'(err_count), 0);
      check_val({tag, ":run_fidx"}, 64'(first_err_idx), 0);
      check_val({tag, ":run_fobs"}, 64'(first_err_obs), 0);

      i   = 0;
      cyc = 0;
      while (i < int'(NV) && cyc < 100) begin
         case (gap_mode)
            0:       acc = 1'b1;
            1:       acc = gap_pat[cyc % 7];
            default: acc = 1'($urandom_range(0, 1));
         endcase
         in_valid = acc;
         observed = acc ? obs_a[i] : $urandom;
         expected = acc ? exp_a[i] : $urandom;
         mask     = acc ? msk_a[i] : '1;
         start    = mid_start && (cyc == 1);
         check_val({tag, ":rdy_run"}, 64'(in_ready), 1);
         @(negedge clk);
         if (acc) i++;
         cyc++;
      end
      start = 1'b0;
      if (i < int'(NV)) check_val({tag, ":timeout"}, 64'(i), 64'(NV));

      // DRAIN: a valid mismatching beat here must be ignored
      in_valid = 1'b1;
      observed = '1;
      expected = '0;
      mask     = '1;
      check_val({tag, ":drain_rdy"}, 64'(in_ready), 0);
      check_val({tag, ":drain_busy"}, 64'(busy), 1);
      check_val({tag, ":drain_done"}, 64'(done), 0);
      @(negedge clk);
      check_val({tag, ":done"}, 64'(done), 1);
      check_val({tag, ":busy"}, 64'(busy), 0);
      check_val({tag, ":rdy"}, 64'(in_ready), 0);
      check_val({tag, ":pass"}, 64'(pass), 64'(ec == 0));
      check_val({tag, ":err"}, 64'(err_count), 64'(ec));
      check_val({tag, ":fidx"}, 64'(first_err_idx), 64'(fi));
      check_val({tag, ":fobs"}, 64'(first_err_obs), 64'(fo));
      check_val({tag, ":fexp"}, 64'(first_err_exp), 64'(fe));
      @(negedge clk);
      in_valid = 1'b0;
      check_val({tag, ":hold_done"}, 64'(done), 1);
      check_val({tag, ":hold_err"}, 64'(err_count), 64'(ec));
   endtask

   initial begin
      logic [W-1:0] o;
      logic [W-1:0] e;

      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      observed = '0;
      expected = '0;
      mask     = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      fill(32'h5, 32'h5, '1);
      run_check("all_match", 0, 0);

      fill(32'hFFFF_0000, 32'h0, 32'h0000_FFFF);
      run_check("masked", 0, 0);

      fill(32'h5, 32'h5, '1);
      obs_a[2] = 32'h0;
      run_check("beat2_err", 0, 0);

      // From DONE with one error, restart; the mid-run start is ignored
      fill(32'h5, 32'h5, '1);
      run_check("restart", 0, 1);

      fill(32'h5, 32'h5, '1);
      obs_a[1] = 32'h4;
      obs_a[3] = 32'h7;
      run_check("gaps", 1, 0);

      fill(32'h1234_5678, 32'h1234_5678, '1);
      obs_a[3] = 32'h0;
      run_check("last_err", 0, 0);

      fill(32'hA5A5_A5A5, 32'h5A5A_5A5A, '1);
      run_check("saturate", 0, 0);

      fill(32'h0, 32'hFFFF_FFFF, '0);
      run_check("mask_zero", 0, 0);

      // Reset mid-run after one mismatching and one matching beat
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      observed = 32'h3;
      expected = 32'h5;
      mask     = '1;
      @(negedge clk);
      observed = 32'h5;
      @(negedge clk);
      in_valid = 1'b0;
      check_val("midrst:err_before", 64'(err_count), 1);
      check_val("midrst:fobs_before", 64'(first_err_obs), 64'(32'h3));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      @(negedge clk);
      check_all_zero("midrst_idle");
      fill(32'h5, 32'h5, '1);
      run_check("after_rst", 0, 0);

      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < NV; k++) begin
            o = $urandom;
            e = $urandom;
            case ($urandom_range(0, 3))
               0: begin exp_a[k] = o; msk_a[k] = $urandom; end
               1: begin exp_a[k] = e; msk_a[k] = '1; end
               2: begin exp_a[k] = e; msk_a[k] = $urandom; end
               default: begin exp_a[k] = e; msk_a[k] = ~(o ^ e); end
            endcase
            obs_a[k] = o;
         end
         run_check("rand", 2, r[0]);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Hardware response checker for gate-level self-test of the std-lib datapath cells (AND2_32, OR2_32, MUX2_1 and similar).
- Consumes a stream of observed/expected word pairs from a stimulus source, with a masked compare per beat.
- Counts mismatches, captures the first failing vector, and reports pass/fail once a fixed number of vectors has been checked.
- Lets simulation and FPGA bring-up share one checking path instead of per-case $display checks.

Parameters:
WIDTH, 32, data width of observed/expected/mask
NUM_VECTORS, 16, beats per check run (>=1)
IDX_W, 4, width of vector index (2^IDX_W >= NUM_VECTORS)
CNT_W, 8, width of error counter (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  observed/expected/mask beat valid
in_ready  output  1  checker accepts a beat this cycle
observed  input  WIDTH  DUT output word
expected  input  WIDTH  golden word
mask  input  WIDTH  1 = bit is compared, 0 = don't care
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  results valid; held until start or rst
pass  output  1  done && err_count==0
err_count  output  CNT_W  mismatching beats, saturates at all-ones
first_err_idx  output  IDX_W  index of first mismatching beat
first_err_obs  output  WIDTH  observed word of first mismatch
first_err_exp  output  WIDTH  expected word of first mismatch

Behaviour:
- Reset (rst=1 at edge): state IDLE; all outputs 0, including in_ready, busy, done, pass, err_count and the first_err_* outputs. Pipeline valid is cleared. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. A start pulse moves to RUN and, at the same edge, clears vec_idx, err_count, the first-error-captured flag and the first_err_* outputs.
- RUN: in_ready=1, busy=1. A beat is accepted at an edge where in_valid && in_ready.
  - On accept, register stage 1 with: mismatch = OR-reduce((observed XOR expected) AND mask), the beat index vec_idx, observed, and expected. Then increment vec_idx.
  - Accepting the beat with vec_idx==NUM_VECTORS-1 moves the state to DRAIN at that edge.
  - in_valid gaps are legal; nothing advances without an accept.
- Stage 2 (the edge after accept, when stage-1 valid):
  - If mismatch, increment err_count, saturating at 2^CNT_W-1.
  - If mismatch and no error has been captured yet, load first_err_idx/obs/exp and set the captured flag.
- DRAIN: in_ready=0, busy=1. Lasts exactly one cycle, so the last beat retires; then DONE.
- DONE: done=1, busy=0, in_ready=0, pass=(err_count==0). All results hold. A start pulse re-enters RUN with the same clearing as from IDLE.
- Latency: last beat accepted at edge E; done=1 and final counts are visible after edge E+1.
- Ignored inputs:
  - start while in RUN or DRAIN.
  - in_valid while in IDLE, DRAIN or DONE.
  - start and in_valid in the same cycle from IDLE: the beat is not accepted (in_ready was 0).
- The first_err_* outputs remain 0 if no mismatch occurs.
- mask=0 on a beat: the beat always passes.

Test Plan:
- WIDTH=32, NUM_VECTORS=4. Start, then 4 consecutive beats with observed=expected=0x00000005, mask=0xFFFFFFFF -> after the edge following the last accept: done=1, pass=1, err_count=0, first_err_*=0.
- Beats 0..3 with observed=0x00000005 except beat 2 observed=0x00000000, expected=0x00000005, full mask -> err_count=1, first_err_idx=2, first_err_obs=0x00000000, first_err_exp=0x00000005, pass=0.
- Every beat observed=0xFFFF0000, expected=0x00000000, mask=0x0000FFFF -> pass=1, err_count=0.
- in_valid toggled 1,0,0,1,1,0,1; mismatches on beats 1 and 3 -> only 4 beats accepted, err_count=2, first_err_idx=1. in_ready=0 during DRAIN.
- rst=1 after 2 accepted beats, one of them mismatching -> next cycle all outputs 0, state IDLE. A new start plus 4 matching beats -> pass=1, err_count=0.
- From DONE with err_count=1, pulse start and send 4 matching beats -> done drops on the start edge, then pass=1 and err_count=0. A start pulse issued mid-RUN has no effect.
